// File: rtl/bcd_scan_display.sv
// Six-digit multiplexed 7-segment driver for the BCD clock. The digits are snapshotted
// once per frame so the display never tears. Supports per-digit blink and hour-tens blanking.
module bcd_scan_display #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] sec_l,
    input  logic [2:0] sec_h,
    input  logic [3:0] min_l,
    input  logic [2:0] min_h,
    input  logic [3:0] hour_l,
    input  logic [1:0] hour_h,
    input  logic [5:0] blink_en,
    input  logic       lz_blank,
    output logic [6:0] seg,
    output logic [5:0] dig_sel,
    output logic       frame_start
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            blink_ph_q, blink_ph_d;
    logic [5:0][3:0] shadow_q, shadow_d;
    logic [5:0]      blink_sh_q, blink_sh_d;
    logic [6:0]      seg_q, seg_d;
    logic [5:0]      dig_sel_q, dig_sel_d;
    logic            frame_start_q, frame_start_d;

    logic            tick;
    logic            wrap;
    logic [3:0]      cur_digit;
    logic            cur_blink;

    function automatic logic [6:0] encode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111100;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1100111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        presc_d       = presc_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        blink_ph_d    = blink_ph_q;
        shadow_d      = shadow_q;
        blink_sh_d    = blink_sh_q;
        cur_digit     = 4'd0;
        cur_blink     = 1'b0;

        tick = (presc_q == PRESC_MAX);
        wrap = tick && (idx_q == 3'd5);

        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
            idx_d = wrap ? 3'd0 : idx_q + 3'd1;
        end

        // The frame boundary takes the snapshot and advances the blink timebase on the same edge.
        if (wrap) begin
            shadow_d   = {{2'b00, hour_h}, hour_l, {1'b0, min_h}, min_l, {1'b0, sec_h}, sec_l};
            blink_sh_d = blink_en;
            if (frame_q == FRAME_MAX) begin
                frame_d    = '0;
                blink_ph_d = ~blink_ph_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
        frame_start_d = wrap;

        for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = shadow_q[i];
                cur_blink = blink_sh_q[i];
            end
        end

        dig_sel_d = 6'b000001 << idx_q;
        seg_d     = encode(cur_digit);
        if (blink_ph_q && cur_blink) begin
            seg_d = 7'b0000000;
        end
        // lz_blank is deliberately live: toggling it takes effect on the very next hour-tens slot.
        if ((idx_q == 3'd5) && lz_blank && (shadow_q[5] == 4'd0)) begin
            seg_d = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            presc_q       <= '0;
            idx_q         <= 3'd0;
            frame_q       <= '0;
            blink_ph_q    <= 1'b0;
            shadow_q      <= '0;
            blink_sh_q    <= 6'b000000;
            seg_q         <= 7'b0000000;
            dig_sel_q     <= 6'b000001;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            frame_q       <= frame_d;
            blink_ph_q    <= blink_ph_d;
            shadow_q      <= shadow_d;
            blink_sh_q    <= blink_sh_d;
            seg_q         <= seg_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign dig_sel     = dig_sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=4, BLINK_FRAMES=2 (24-cycle frames).
// A vector table covers decoding and blanking; hand sequences cover reset, snapshot and blink timing.
module tb_bcd_scan_display;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111100;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1100111;
    localparam logic [6:0] SX = 7'b0000000;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] sec_l;
    logic [2:0] sec_h;
    logic [3:0] min_l;
    logic [2:0] min_h;
    logic [3:0] hour_l;
    logic [1:0] hour_h;
    logic [5:0] blink_en;
    logic       lz_blank;
    logic [6:0] seg;
    logic [5:0] dig_sel;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    // Segment expectations are packed {digit5, ..., digit0}.
    typedef struct {
        logic [3:0]      sl;
        logic [2:0]      sh;
        logic [3:0]      ml;
        logic [2:0]      mh;
        logic [3:0]      hl;
        logic [1:0]      hh;
        logic            lz;
        logic [5:0][6:0] segs;
    } vec_t;

    vec_t vecs [8];

    bcd_scan_display #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .clr(clr),
        .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
        .hour_l(hour_l), .hour_h(hour_h),
        .blink_en(blink_en), .lz_blank(lz_blank),
        .seg(seg), .dig_sel(dig_sel), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_time(input logic [3:0] sl, input logic [2:0] sh, input logic [3:0] ml,
                            input logic [2:0] mh, input logic [3:0] hl, input logic [1:0] hh);
        sec_l = sl; sec_h = sh; min_l = ml; min_h = mh; hour_l = hl; hour_h = hh;
    endtask

    // Called at a negedge; applies clr across exactly one posedge and checks the reset outputs.
    task automatic do_reset(input string name);
        clr = 1'b1;
        @(negedge clk);
        check({name, "_seg"}, 32'(seg), 32'(7'b0000000));
        check({name, "_sel"}, 32'(dig_sel), 32'(6'b000001));
        check({name, "_fs"}, 32'(frame_start), 32'd0);
        clr = 1'b0;
    endtask

    // Called at the negedge just before the first digit-0 output of a frame; walks all 24 cycles.
    task automatic check_frame(input string name, input logic [5:0][6:0] segs);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check($sformatf("%s_seg_c%0d", name, c), 32'(seg), 32'(segs[c/4]));
            check($sformatf("%s_sel_c%0d", name, c), 32'(dig_sel), 32'd1 << (c / 4));
            check($sformatf("%s_fs_c%0d", name, c), 32'(frame_start), (c == 23) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        check({name, "_frame_start_seen"}, 32'(frame_start), 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'd8,  3'd5, 4'd9,  3'd5, 4'd3,  2'd2, 1'b0, {S2, S3, S5, S9, S5, S8}};
        vecs[1] = '{4'd1,  3'd4, 4'd0,  3'd3, 4'd7,  2'd0, 1'b1, {SX, S7, S3, S0, S4, S1}};
        vecs[2] = '{4'd6,  3'd0, 4'd2,  3'd4, 4'd6,  2'd1, 1'b1, {S1, S6, S4, S2, S0, S6}};
        vecs[3] = '{4'd0,  3'd0, 4'd0,  3'd0, 4'd9,  2'd0, 1'b0, {S0, S9, S0, S0, S0, S0}};
        vecs[4] = '{4'hC,  3'd5, 4'd4,  3'd3, 4'd2,  2'd1, 1'b1, {S1, S2, S3, S4, S5, SX}};
        vecs[5] = '{4'd9,  3'd7, 4'd5,  3'd6, 4'd8,  2'd3, 1'b1, {S3, S8, S6, S5, S7, S9}};
        vecs[6] = '{4'd0,  3'd0, 4'hA,  3'd0, 4'hF,  2'd0, 1'b0, {S0, SX, S0, SX, S0, S0}};
        vecs[7] = '{4'd0,  3'd0, 4'd0,  3'd0, 4'd0,  2'd0, 1'b1, {SX, S0, S0, S0, S0, S0}};

        // Reset, then the first frame shows the zeroed shadow and the next one the live inputs.
        clr = 1'b1;
        set_time(4'd7, 3'd0, 4'd0, 3'd0, 4'd0, 2'd0);
        blink_en = 6'b000000;
        lz_blank = 1'b0;
        @(negedge clk);
        do_reset("rst0");
        check_frame("a_f0", {S0, S0, S0, S0, S0, S0});
        check_frame("a_f1", {S0, S0, S0, S0, S0, S7});

        // Decode and blanking table: each vector is captured at a wrap and checked for one frame.
        for (int i = 0; i < 8; i++) begin
            set_time(vecs[i].sl, vecs[i].sh, vecs[i].ml, vecs[i].mh, vecs[i].hl, vecs[i].hh);
            lz_blank = vecs[i].lz;
            wait_frame($sformatf("v%0d", i));
            check_frame($sformatf("v%0d", i), vecs[i].segs);
        end

        // Snapshot integrity: inputs changed mid-frame must not reach the display until the next wrap.
        set_time(4'd8, 3'd5, 4'd9, 3'd5, 4'd3, 2'd2);
        lz_blank = 1'b0;
        wait_frame("snap");
        for (int c = 0; c < 24; c++) begin
            if (c == 6) begin
                sec_l  = 4'd9;
                hour_l = 4'd1;
            end
            @(negedge clk);
            check($sformatf("snap_old_seg_c%0d", c), 32'(seg), 32'(vecs[0].segs[c/4]));
        end
        check_frame("snap_new", {S2, S1, S5, S9, S5, S9});

        // Blink on digits 0 and 1: phase toggles every two frames counted from reset.
        set_time(4'd8, 3'd5, 4'd9, 3'd5, 4'd3, 2'd2);
        blink_en = 6'b000011;
        @(negedge clk);
        do_reset("rst1");
        check_frame("b_f0", {S0, S0, S0, S0, S0, S0});
        check_frame("b_f1", {S2, S3, S5, S9, S5, S8});
        check_frame("b_f2", {S2, S3, S5, S9, SX, SX});
        check_frame("b_f3", {S2, S3, S5, S9, SX, SX});
        check_frame("b_f4", {S2, S3, S5, S9, S5, S8});
        check_frame("b_f5", {S2, S3, S5, S9, S5, S8});

        // Frame 6 is blanked again; reset while index=3 must restart everything with phase 0.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("m_f6_seg_c%0d", c), 32'(seg), 32'(((c / 4) == 2) ? S9 : SX));
        end
        do_reset("rst_mid");
        check_frame("m_f0", {S0, S0, S0, S0, S0, S0});
        check_frame("m_f1", {S2, S3, S5, S9, S5, S8});
        check_frame("m_f2", {S2, S3, S5, S9, SX, SX});

        // lz_blank is sampled live: raising it mid-frame blanks this frame's hour-tens slot.
        set_time(4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 2'd0);
        blink_en = 6'b000000;
        lz_blank = 1'b0;
        wait_frame("lz");
        for (int c = 0; c < 24; c++) begin
            if (c == 8) begin
                lz_blank = 1'b1;
            end
            @(negedge clk);
            check($sformatf("lz_live_seg_c%0d", c), 32'(seg), 32'(((c / 4) == 5) ? SX : S0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Consumes the six BCD time digits from the clock counter (sec_l, sec_h, min_l, min_h, hour_l, hour_h).
- Time-multiplexes them onto one shared 7-segment bus with a one-hot digit select.
- Takes a tear-free snapshot of the digits once per frame; supports per-digit blinking for time-set feedback and leading-zero blanking of the hour tens digit.
- Sits between the clock counter and the board display pins.

Parameters:
- SCAN_DIV, 1000: clk cycles each digit is displayed; legal range ≥ 2.
- BLINK_FRAMES, 50: frames per blink half-period; legal range ≥ 1.

Ports:
- clk  input  1  system clock, single clock domain.
- clr  input  1  reset, synchronous, active-high.
- sec_l  input  4  seconds units BCD.
- sec_h  input  3  seconds tens BCD.
- min_l  input  4  minutes units BCD.
- min_h  input  3  minutes tens BCD.
- hour_l  input  4  hours units BCD.
- hour_h  input  2  hours tens BCD.
- blink_en  input  6  per-digit blink enable; bit i applies to digit i (0 = sec_l … 5 = hour_h).
- lz_blank  input  1  blank digit 5 when the hour tens digit is 0.
- seg  output  7  segment bus {g,f,e,d,c,b,a}, active-high, registered.
- dig_sel  output  6  one-hot digit enable, active-high, registered.
- frame_start  output  1  one-cycle pulse marking the start of each new frame.

Behaviour:
- Reset: clr high at a clk edge clears everything:
  - prescaler = 0, index = 0, frame counter = 0, blink phase = 0;
  - all shadow digit and blink registers = 0;
  - outputs: seg = 7'b0000000, dig_sel = 6'b000001, frame_start = 0.
  - Reset applied mid-frame or mid-blink aborts immediately; no partial state is retained.
- Prescaler:
  - counts 0 .. SCAN_DIV-1, then wraps to 0;
  - tick = (prescaler == SCAN_DIV-1).
- Index:
  - on a tick, index advances 0→1→…→5→0;
  - otherwise it holds.
- Snapshot:
  - taken on the tick edge where index wraps 5→0;
  - captures all six digits, zero-extended to 4 bits, plus blink_en into the shadow registers;
  - input changes at any other time do not affect the display until the next wrap.
  - After reset, the first frame shows the shadow values (all zero).
- Frame counter and blink phase:
  - the frame counter increments on each 5→0 wrap;
  - when it reaches BLINK_FRAMES-1 on a wrap, it clears to 0 and the blink phase toggles.
- Output register, updated every clk edge when clr is low, from the current (pre-edge) index and shadow values:
  - dig_sel = one-hot(index);
  - seg = encode(shadow digit[index]);
  - seg = 0 when blink phase = 1 and shadow blink bit[index] = 1;
  - seg = 0 when index = 5, lz_blank = 1 and shadow hour_h = 0. lz_blank is sampled live, not snapshotted.
  - Latency: seg and dig_sel trail an index change by exactly one cycle.
  - dig_sel stays asserted while a digit is blanked; only seg goes to 0.
- Encoding:

  | Value | seg |
  |---|---|
  | 0 | 0111111 |
  | 1 | 0000110 |
  | 2 | 1011011 |
  | 3 | 1001111 |
  | 4 | 1100110 |
  | 5 | 1101101 |
  | 6 | 1111100 |
  | 7 | 0000111 |
  | 8 | 1111111 |
  | 9 | 1100111 |
  | 10–15 (invalid) | 0000000 |

- frame_start: high for exactly the one cycle immediately after each 5→0 wrap edge; never asserted for the implicit frame following reset.
- Simultaneous events:
  - a wrap that coincides with a blink toggle snapshots and toggles on the same edge;
  - the new frame's digit 0 already uses the new shadow values and the new phase.

Test Plan (SCAN_DIV=4, BLINK_FRAMES=2):
1. Reset then release, inputs sec_l=7, others 0:
   - cycle 1 after release: seg=0111111 (zero from reset shadow), dig_sel=000001;
   - dig_sel steps 000010 … 100000 every 4 cycles;
   - after the first wrap: frame_start pulses once, and digit 0 shows 0000111.
2. Snapshot integrity: inputs 23:59:58, change sec_l to 9 while index=3:
   - frame shows sec_l=8 (1111111) until the next wrap;
   - then digit 0 shows 1100111.
3. Blink: blink_en=000011, stable inputs:
   - digits 0 and 1 have seg=0000000 in frames 2–3;
   - digits 0 and 1 show their values in frames 0–1 and 4–5;
   - dig_sel still cycles through all six digits.
4. Leading-zero blank: hour_h=0, lz_blank=1 → index-5 slot seg=0000000.
   - Set hour_h=1 → slot shows 0000110 from the next frame.
   - Set lz_blank=0 with hour_h=0 → slot shows 0111111.
5. Invalid digit: force sec_l=4'hC → digit 0 seg=0000000; all other digits unaffected.
6. Mid-frame reset: assert clr for 1 cycle while index=3 with blink phase=1:
   - next cycle: seg=0000000, dig_sel=000001;
   - index restarts at 0, blink phase=0;
   - no frame_start until the next 5→0 wrap.
